// File: rtl/rx_tx_pkg.sv
// Shared UART-side definitions: receive packer states and defaults, transmit-side state constants.
package rx_tx_pkg;

  localparam int RX_TO_W_DEF      = 20;
  localparam int RX_TO_CYCLES_DEF = 100000;

  // Encoding doubles as the count of bytes held in the partial word.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HAVE1 = 2'd1,
    HAVE2 = 2'd2,
    HAVE3 = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [1:0] rx_count(input rx_state_e s);
    return logic'(s[1]) ? {1'b1, s[0]} : {1'b0, s[0]};
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; history resets high so a level already high at reset release is ignored.
module rise_detect (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) prev_q <= 1'b1;
    else          prev_q <= sig_i;
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/rx_pack_8to32.sv
// Packs UART bytes MSB-first into 32-bit words, discarding partial words after an inter-byte timeout.
//   state | meaning
//   IDLE  | no bytes held, timeout counter parked at 0
//   HAVE1 | one byte in partial register
//   HAVE2 | two bytes in partial register
//   HAVE3 | three bytes held, next byte completes the word
module rx_pack_8to32 import rx_tx_pkg::*; #(
  parameter int TO_W      = RX_TO_W_DEF,
  parameter int TO_CYCLES = RX_TO_CYCLES_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [7:0]  in_8,
  input  logic        rx_done,
  output logic [31:0] out_32,
  output logic        data_rdy,
  output logic        frame_err,
  output logic [1:0]  byte_cnt
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  logic            byte_acc;
  logic            expire;
  rx_state_e       state_q;
  logic [23:0]     part_q;
  logic [31:0]     word_q;
  logic            rdy_q;
  logic            ferr_q;
  logic [TO_W-1:0] to_q;
  logic [TO_W-1:0] to_d;

  rise_detect u_rx_done_rise (
    .clk_i   (sys_clk),
    .rst_n_i (reset),
    .sig_i   (rx_done),
    .rise_o  (byte_acc)
  );

  // A byte arriving on the expiry cycle wins over the timeout.
  assign expire = (state_q != IDLE) && !byte_acc && (to_q == TO_LAST);

  always_comb begin
    to_d = to_q + TO_W'(1);
    if (state_q == IDLE || byte_acc || expire) to_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      part_q  <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b0;
      ferr_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      rdy_q  <= 1'b0;
      ferr_q <= 1'b0;
      to_q   <= to_d;
      if (byte_acc) begin
        unique case (state_q)
          IDLE: begin
            part_q  <= {part_q[15:0], in_8};
            state_q <= HAVE1;
          end
          HAVE1: begin
            part_q  <= {part_q[15:0], in_8};
            state_q <= HAVE2;
          end
          HAVE2: begin
            part_q  <= {part_q[15:0], in_8};
            state_q <= HAVE3;
          end
          HAVE3: begin
            word_q  <= {part_q, in_8};
            part_q  <= '0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end else if (expire) begin
        part_q  <= '0;
        ferr_q  <= 1'b1;
        state_q <= IDLE;
      end
    end
  end

  assign out_32    = word_q;
  assign data_rdy  = rdy_q;
  assign frame_err = ferr_q;
  assign byte_cnt  = rx_count(state_q);

endmodule

// File: tb/tb_rx_pack_8to32.sv
// Directed bench: instance A uses the default timeout, instance B a 16-cycle timeout.
module tb_rx_pack_8to32;

  logic        sys_clk;
  logic        reset;
  logic [7:0]  in_8      [2];
  logic        rx_done   [2];
  logic [31:0] out_32    [2];
  logic        data_rdy  [2];
  logic        frame_err [2];
  logic [1:0]  byte_cnt  [2];

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_cnt  [2];
  int ferr_cnt [2];
  int both_cnt = 0;

  typedef struct {
    logic [3:0][7:0] b;
    int              hold;
    int              gap;
    logic [31:0]     exp_word;
  } vec_t;

  vec_t vecs [4];

  rx_pack_8to32 u_dut_a (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .in_8      (in_8[0]),
    .rx_done   (rx_done[0]),
    .out_32    (out_32[0]),
    .data_rdy  (data_rdy[0]),
    .frame_err (frame_err[0]),
    .byte_cnt  (byte_cnt[0])
  );

  rx_pack_8to32 #(.TO_CYCLES(16)) u_dut_b (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .in_8      (in_8[1]),
    .rx_done   (rx_done[1]),
    .out_32    (out_32[1]),
    .data_rdy  (data_rdy[1]),
    .frame_err (frame_err[1]),
    .byte_cnt  (byte_cnt[1])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    rdy_cnt[0] = 0; rdy_cnt[1] = 0; ferr_cnt[0] = 0; ferr_cnt[1] = 0;
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (data_rdy[i] === 1'b1) rdy_cnt[i] = rdy_cnt[i] + 1;
      if (frame_err[i] === 1'b1) ferr_cnt[i] = ferr_cnt[i] + 1;
      if (data_rdy[i] === 1'b1 && frame_err[i] === 1'b1) both_cnt = both_cnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input int hold, input int gap,
                           output logic [1:0] cnt, output logic rdy);
    in_8[sel]    = b;
    rx_done[sel] = 1'b1;
    tick();
    cnt = byte_cnt[sel];
    rdy = data_rdy[sel];
    for (int i = 1; i < hold; i++) tick();
    rx_done[sel] = 1'b0;
    tick();
    for (int i = 0; i < gap; i++) tick();
  endtask

  initial begin
    logic [1:0]  c;
    logic        r;
    logic [31:0] prev_word;
    int          rdy0, ferr0, ferr1;
    logic [31:0] w1, w2;

    vecs[0] = '{b: {8'hDE, 8'hAD, 8'hBE, 8'hEF}, hold: 1,  gap: 100, exp_word: 32'hDEADBEEF};
    vecs[1] = '{b: {8'h01, 8'h02, 8'h03, 8'h04}, hold: 10, gap: 3,   exp_word: 32'h01020304};
    vecs[2] = '{b: {8'hCA, 8'hFE, 8'h00, 8'hFF}, hold: 2,  gap: 7,   exp_word: 32'hCAFE00FF};
    vecs[3] = '{b: {8'h80, 8'h00, 8'h00, 8'h01}, hold: 1,  gap: 0,   exp_word: 32'h80000001};

    // Reset with rx_done already high on both instances.
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_8[i]    = 8'h5A;
      rx_done[i] = 1'b1;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_out_%0d", i),  out_32[i], 32'h0);
      check($sformatf("rst_cnt_%0d", i),  32'(byte_cnt[i]), 32'h0);
      check($sformatf("rst_rdy_%0d", i),  32'(data_rdy[i]), 32'h0);
      check($sformatf("rst_ferr_%0d", i), 32'(frame_err[i]), 32'h0);
    end
    reset = 1'b1;
    tick(); tick(); tick();
    for (int i = 0; i < 2; i++) check($sformatf("held_high_no_byte_%0d", i), 32'(byte_cnt[i]), 32'h0);
    rx_done[0] = 1'b0;
    rx_done[1] = 1'b0;
    tick();

    // Table-driven words on instance A.
    prev_word = 32'h0;
    for (int v = 0; v < 4; v++) begin
      rdy0  = rdy_cnt[0];
      ferr0 = ferr_cnt[0];
      for (int k = 0; k < 4; k++) begin
        if (k == 3) check($sformatf("v%0d_out_holds_prev", v), out_32[0], prev_word);
        send_byte(0, vecs[v].b[3-k], vecs[v].hold, vecs[v].gap, c, r);
        check($sformatf("v%0d_cnt_b%0d", v, k), 32'(c), 32'((k + 1) % 4));
        if (k == 3) check($sformatf("v%0d_rdy", v), 32'(r), 32'h1);
      end
      check($sformatf("v%0d_word", v), out_32[0], vecs[v].exp_word);
      check($sformatf("v%0d_rdy_pulses", v), 32'(rdy_cnt[0] - rdy0), 32'h1);
      check($sformatf("v%0d_no_ferr", v), 32'(ferr_cnt[0] - ferr0), 32'h0);
      prev_word = vecs[v].exp_word;
    end

    // Timeout on instance B: AA, BB, silence.
    ferr1 = ferr_cnt[1];
    send_byte(1, 8'hAA, 1, 2, c, r);
    check("to_cnt_aa", 32'(c), 32'h1);
    in_8[1] = 8'hBB; rx_done[1] = 1'b1;
    tick();
    check("to_cnt_bb", 32'(byte_cnt[1]), 32'h2);
    rx_done[1] = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("to_no_ferr_early", 32'(frame_err[1]), 32'h0);
    check("to_cnt_before", 32'(byte_cnt[1]), 32'h2);
    tick();
    check("to_ferr_pulse", 32'(frame_err[1]), 32'h1);
    check("to_cnt_cleared", 32'(byte_cnt[1]), 32'h0);
    check("to_out_untouched", out_32[1], 32'h0);
    send_byte(1, 8'h11, 1, 0, c, r);
    check("to_next_byte_immediate", 32'(c), 32'h1);
    send_byte(1, 8'h22, 1, 0, c, r);
    send_byte(1, 8'h33, 1, 0, c, r);
    send_byte(1, 8'h44, 1, 2, c, r);
    check("to_next_word", out_32[1], 32'h11223344);
    check("to_ferr_once", 32'(ferr_cnt[1] - ferr1), 32'h1);

    // Byte arriving exactly on the expiry cycle.
    ferr1 = ferr_cnt[1];
    in_8[1] = 8'h10; rx_done[1] = 1'b1;
    tick();
    rx_done[1] = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    in_8[1] = 8'h20; rx_done[1] = 1'b1;
    tick();
    check("edge_cnt_inc", 32'(byte_cnt[1]), 32'h2);
    check("edge_no_ferr", 32'(frame_err[1]), 32'h0);
    rx_done[1] = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("edge_ctr_cleared", 32'(ferr_cnt[1] - ferr1), 32'h0);
    tick();
    check("edge_later_timeout", 32'(frame_err[1]), 32'h1);
    tick();

    // Reset mid-word on instance A.
    rdy0  = rdy_cnt[0];
    ferr0 = ferr_cnt[0];
    send_byte(0, 8'h99, 1, 1, c, r);
    send_byte(0, 8'h9A, 1, 1, c, r);
    send_byte(0, 8'h9B, 1, 1, c, r);
    check("mid_cnt3", 32'(c), 32'h3);
    reset = 1'b0;
    tick();
    check("mid_rst_out", out_32[0], 32'h0);
    check("mid_rst_cnt", 32'(byte_cnt[0]), 32'h0);
    rx_done[0] = 1'b1;
    tick();
    reset = 1'b1;
    tick(); tick();
    check("mid_release_high", 32'(byte_cnt[0]), 32'h0);
    rx_done[0] = 1'b0;
    tick();
    send_byte(0, 8'h55, 1, 1, c, r);
    send_byte(0, 8'h66, 1, 1, c, r);
    send_byte(0, 8'h77, 1, 1, c, r);
    send_byte(0, 8'h88, 1, 1, c, r);
    check("mid_word", out_32[0], 32'h55667788);
    check("mid_no_ferr", 32'(ferr_cnt[0] - ferr0), 32'h0);
    check("mid_rdy_once", 32'(rdy_cnt[0] - rdy0), 32'h1);

    // Back-to-back words, one-cycle pulses every two cycles.
    rdy0 = rdy_cnt[0];
    send_byte(0, 8'h12, 1, 0, c, r);
    send_byte(0, 8'h34, 1, 0, c, r);
    send_byte(0, 8'h56, 1, 0, c, r);
    in_8[0] = 8'h78; rx_done[0] = 1'b1;
    tick();
    w1 = out_32[0];
    rx_done[0] = 1'b0;
    tick();
    send_byte(0, 8'h9A, 1, 0, c, r);
    send_byte(0, 8'hBC, 1, 0, c, r);
    send_byte(0, 8'hDE, 1, 0, c, r);
    in_8[0] = 8'hF0; rx_done[0] = 1'b1;
    tick();
    w2 = out_32[0];
    rx_done[0] = 1'b0;
    tick(); tick();
    check("b2b_word1", w1, 32'h12345678);
    check("b2b_word2", w2, 32'h9ABCDEF0);
    check("b2b_rdy_pulses", 32'(rdy_cnt[0] - rdy0), 32'h2);

    check("rdy_ferr_exclusive", 32'(both_cnt), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_pack_8to32.md
RX_PACK_8TO32 -- requirements
Module: rx_pack_8to32

Interface
REQ-001 SHALL have parameter TO_W, default 20, meaning the inter-byte timeout counter width.
REQ-002 SHALL have parameter TO_CYCLES, default 100000, meaning the inter-byte timeout in sys_clk cycles (must be less than 2^TO_W).
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_8, input, 8 bits: received byte from the UART receiver; valid whenever rx_done is high.
REQ-006 SHALL have port rx_done, input, 1 bit: UART byte-complete flag, synchronous to sys_clk; may stay high for multiple cycles.
REQ-007 SHALL have port out_32, output, 32 bits: last fully assembled word.
REQ-008 SHALL have port data_rdy, output, 1 bit: one-cycle pulse marking that out_32 was updated.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse marking that a partial word was discarded on timeout.
REQ-010 SHALL have port byte_cnt, output, 2 bits: number of bytes currently held in the partial word.

Function
REQ-011 SHALL accept a byte only on a cycle where rx_done is 1 and its registered value from the previous cycle is 0 (rising edge); a level held high yields exactly one byte.
REQ-012 SHALL assemble bytes MSB-first: the 1st byte goes to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-013 SHALL use the FSM states IDLE, HAVE1, HAVE2, HAVE3; an accepted byte advances IDLE->HAVE1->HAVE2->HAVE3, and HAVE3->IDLE on the 4th byte.
REQ-014 SHALL keep the partial word in a separate shift register; out_32 SHALL never show a partial word.
REQ-015 SHALL, when the 4th byte is accepted in cycle t, load out_32 with the complete word and assert data_rdy for exactly cycle t+1.
REQ-016 SHALL hold out_32 stable until the next complete word arrives.
REQ-017 SHALL drive byte_cnt as 0/1/2/3 for IDLE/HAVE1/HAVE2/HAVE3.
REQ-018 SHALL hold the timeout counter at 0 in IDLE, clear it on every accepted byte, and otherwise increment it each cycle while in HAVE1 to HAVE3.
REQ-019 SHALL, when the counter reaches TO_CYCLES-1 with no byte accepted that cycle, discard the partial word, return to IDLE, and pulse frame_err on the next cycle.
REQ-020 SHALL give an accepted byte priority over timeout expiry in the same cycle: the byte is accepted and the counter cleared.
REQ-021 SHALL never assert data_rdy and frame_err in the same cycle.
REQ-022 SHALL let the first byte of a new word be accepted in the cycle immediately after a completed word or a timeout.

Reset
REQ-023 SHALL, while reset=0 at a clock edge, set out_32=0, data_rdy=0, frame_err=0, byte_cnt=0, state=IDLE, the partial register=0, the counter=0, and the rx_done history=1.
REQ-024 SHALL, when reset occurs mid-word, discard the partial word without pulsing frame_err or data_rdy.
REQ-025 SHALL NOT treat an rx_done that is already high when reset releases as a new byte.

Structure
REQ-026 SHALL place the FSM state encodings (2 bits) and the default TO_W/TO_CYCLES values in the shared package rx_tx_pkg, alongside the transmit-side state constants.
REQ-027 SHALL instantiate exactly one sub-module, rise_detect (1-bit registered rising-edge detector with synchronous active-low reset), for rx_done.

Verification
REQ-028 SHALL cover this scenario: bytes 0xDE, 0xAD, 0xBE, 0xEF with 100-cycle gaps -> out_32=0xDEADBEEF, one data_rdy pulse, frame_err never asserted.
REQ-029 SHALL cover this scenario: rx_done held high 10 cycles per byte, bytes 0x01..0x04 -> out_32=0x01020304, byte_cnt steps 1,2,3,0.
REQ-030 SHALL cover this scenario: TO_CYCLES=16, bytes 0xAA, 0xBB, then silence -> frame_err pulses 16 cycles after 0xBB is accepted, byte_cnt=0; then 0x11..0x44 -> out_32=0x11223344.
REQ-031 SHALL cover this scenario: TO_CYCLES=16, byte edge exactly on the expiry cycle -> no frame_err, byte_cnt increments.
REQ-032 SHALL cover this scenario: reset pulsed after 3 bytes, then 0x55..0x88 -> out_32=0x55667788, no frame_err, and out_32 reads 0 during the reset.
REQ-033 SHALL cover this scenario: back-to-back words with 1-cycle rx_done pulses every 2 cycles -> two data_rdy pulses and both words correct.
